prog_updown_counter: RTL and testbench
======================================

PROG_UPDOWN_COUNTER -- requirements
Module: prog_updown_counter

Interface
REQ-001 The block SHALL have parameter WIDTH, default 16, which sets the count width in bits (minimum 2).
REQ-002 The block SHALL have parameter STEP_W, default 4, which sets the step input width in bits (minimum 1, at most WIDTH).
REQ-003 The block SHALL have parameter EVT_W, default 8, which sets the boundary-event counter width in bits.
REQ-004 The block SHALL have the following ports:
  clk  in  1  clock; all state updates on the rising edge.
  reset  in  1  asynchronous, active-high reset.
  en  in  1  count enable.
  up_down  in  1  direction: 1 = up, 0 = down.
  load  in  1  synchronous load strobe.
  load_val  in  WIDTH  value to load.
  step  in  STEP_W  increment/decrement amount.
  max_val  in  WIDTH  upper bound of the count range; the range is 0..max_val inclusive.
  sat  in  1  boundary mode: 1 = saturate, 0 = wrap.
  count  out  WIDTH  registered count.
  ovf  out  1  registered one-cycle pulse on an upper-bound event.
  unf  out  1  registered one-cycle pulse on a lower-bound event.
  at_max  out  1  combinational: count == max_val.
  at_zero  out  1  combinational: count == 0.
  evt_cnt  out  EVT_W  registered count of boundary events.

Function
REQ-005 Each cycle SHALL apply exactly one action, in priority order: reset, then load, then en; with none of these active, count and evt_cnt SHALL hold and ovf/unf SHALL be 0.
REQ-006 Load SHALL set count to min(load_val, max_val), clear evt_cnt to 0, and drive ovf = unf = 0 on the next cycle, regardless of en.
REQ-007 The effective step SHALL be s = min(zero-extended step, max_val).
REQ-008 With s = 0 and en = 1, count SHALL hold and no event SHALL be flagged.
REQ-009 All range arithmetic SHALL be computed at WIDTH+1 bits, with no truncation before the compare.
REQ-010 For up counting with count + s <= max_val, count SHALL become count + s and no event SHALL be flagged.
REQ-011 For up counting with count + s > max_val:
  - the event SHALL be an upper-bound event (ovf = 1 next cycle);
  - in wrap mode, count SHALL become count + s - (max_val + 1);
  - in saturate mode, count SHALL become max_val.
REQ-012 For down counting with s <= count, count SHALL become count - s and no event SHALL be flagged.
REQ-013 For down counting with s > count:
  - the event SHALL be a lower-bound event (unf = 1 next cycle);
  - in wrap mode, count SHALL become count + (max_val + 1) - s;
  - in saturate mode, count SHALL become 0.
REQ-014 In saturate mode, an event SHALL be flagged even when count already sits at the bound (e.g. count == max_val, up, s >= 1).
REQ-015 Range fault: if count > max_val on an enabled, non-load cycle (max_val was lowered), count SHALL become 0, ovf SHALL pulse regardless of direction, and the cycle SHALL count as one event.
REQ-016 evt_cnt SHALL increment by 1 on each cycle that sets ovf or unf, and SHALL saturate at all-ones.
REQ-017 ovf and unf SHALL never be 1 in the same cycle, and each SHALL be 1 for exactly the cycle following its event.
REQ-018 max_val = 0 SHALL be legal: count stays 0; in wrap mode an enabled step s = 0 flags nothing; in saturate mode only REQ-014 applies with s = 0, so nothing is flagged.
REQ-019 sat, up_down, step and max_val SHALL be sampled only on the edge where they are used; there SHALL be no internal pipelining, giving a 1-cycle latency from inputs to count/ovf/unf/evt_cnt.

Reset
REQ-020 Asserting reset SHALL immediately set count = 0, ovf = 0, unf = 0 and evt_cnt = 0, independent of clk.
REQ-021 After reset, at_zero SHALL be 1 and at_max SHALL equal (max_val == 0).
REQ-022 Reset asserted mid-operation SHALL abandon any pending update, with no event counted.
REQ-023 The first update after reset deassertion SHALL occur on the first rising clk edge at which reset is low.

Verification
REQ-024 Wrap up: max_val=9, step=3, sat=0, up, count=8 -> count=1, ovf=1 for one cycle, evt_cnt=1.
REQ-025 Wrap down: max_val=9, step=3, sat=0, down, count=1 -> count=8, unf=1; the next step gives count=5, unf=0.
REQ-026 Saturate: max_val=0xFFFF, step=1, sat=1, up from 0xFFFE -> 0xFFFF with no flag; then 0xFFFF with ovf=1 on each further cycle; evt_cnt climbs and holds at 0xFF.
REQ-027 Load priority: load=1, en=1, load_val=20, max_val=15 -> count=15, at_max=1, evt_cnt=0, no flags.
REQ-028 Range fault and s = 0: count=12, then max_val set to 10, en=1 -> count=0 with ovf=1; then step=0 -> count holds at 0, no flags.
REQ-029 Async reset: reset pulsed between clock edges mid-count -> count, evt_cnt and flags read 0 before the next edge; counting resumes from 0.

Source files
------------

// File: rtl/prog_updown_counter.sv
// Programmable up/down counter over 0..max_val with wrap or saturate boundary
// handling, one-cycle ovf/unf pulses and a saturating boundary-event counter.
module prog_updown_counter #(
  parameter int WIDTH  = 16,
  parameter int STEP_W = 4,
  parameter int EVT_W  = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              en,
  input  logic              up_down,
  input  logic              load,
  input  logic [WIDTH-1:0]  load_val,
  input  logic [STEP_W-1:0] step,
  input  logic [WIDTH-1:0]  max_val,
  input  logic              sat,
  output logic [WIDTH-1:0]  count,
  output logic              ovf,
  output logic              unf,
  output logic              at_max,
  output logic              at_zero,
  output logic [EVT_W-1:0]  evt_cnt
);

  logic [WIDTH-1:0] r_count;
  logic             r_ovf;
  logic             r_unf;
  logic [EVT_W-1:0] r_evt_cnt;

  logic [WIDTH:0]   w_cnt_ext;
  logic [WIDTH:0]   w_max_ext;
  logic [WIDTH:0]   w_max_p1;
  logic [WIDTH:0]   w_step_ext;
  logic [WIDTH:0]   w_s;
  logic [WIDTH:0]   w_sum;
  logic [WIDTH:0]   w_nxt_ext;
  logic [WIDTH-1:0] w_nxt_cnt;
  logic [WIDTH-1:0] w_load_cnt;
  logic             w_ovf;
  logic             w_unf;

  // All range arithmetic is one bit wider than the count so max_val+1 and
  // count+s never truncate before the compare.
  assign w_cnt_ext  = {1'b0, r_count};
  assign w_max_ext  = {1'b0, max_val};
  assign w_max_p1   = w_max_ext + {{WIDTH{1'b0}}, 1'b1};
  assign w_step_ext = {{(WIDTH + 1 - STEP_W){1'b0}}, step};
  assign w_s        = (w_step_ext > w_max_ext) ? w_max_ext : w_step_ext;
  assign w_sum      = w_cnt_ext + w_s;
  assign w_load_cnt = (load_val > max_val) ? max_val : load_val;

  always_comb begin
    w_nxt_ext = w_cnt_ext;
    w_ovf     = 1'b0;
    w_unf     = 1'b0;
    if (w_cnt_ext > w_max_ext) begin
      w_nxt_ext = '0;
      w_ovf     = 1'b1;
    end else if (up_down) begin
      if (w_sum > w_max_ext) begin
        w_ovf     = 1'b1;
        w_nxt_ext = sat ? w_max_ext : (w_sum - w_max_p1);
      end else begin
        w_nxt_ext = w_sum;
      end
    end else begin
      if (w_s > w_cnt_ext) begin
        w_unf     = 1'b1;
        w_nxt_ext = sat ? '0 : (w_cnt_ext + w_max_p1 - w_s);
      end else begin
        w_nxt_ext = w_cnt_ext - w_s;
      end
    end
  end

  assign w_nxt_cnt = w_nxt_ext[WIDTH-1:0];

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_count   <= '0;
      r_ovf     <= 1'b0;
      r_unf     <= 1'b0;
      r_evt_cnt <= '0;
    end else if (load) begin
      r_count   <= w_load_cnt;
      r_ovf     <= 1'b0;
      r_unf     <= 1'b0;
      r_evt_cnt <= '0;
    end else if (en) begin
      r_count <= w_nxt_cnt;
      r_ovf   <= w_ovf;
      r_unf   <= w_unf;
      if ((w_ovf || w_unf) && (r_evt_cnt != '1))
        r_evt_cnt <= r_evt_cnt + {{(EVT_W - 1){1'b0}}, 1'b1};
    end else begin
      r_ovf <= 1'b0;
      r_unf <= 1'b0;
    end
  end

  assign count   = r_count;
  assign ovf     = r_ovf;
  assign unf     = r_unf;
  assign evt_cnt = r_evt_cnt;
  assign at_max  = (r_count == max_val);
  assign at_zero = (r_count == '0);

endmodule

// File: tb/tb_prog_updown_counter.sv
// Randomized bench for prog_updown_counter against an integer-arithmetic
// reference model, plus directed boundary scenarios.
module tb_prog_updown_counter;

  logic        clk = 1'b0;
  logic        reset;
  logic        en;
  logic        up_down;
  logic        load;
  logic [15:0] load_val;
  logic [3:0]  step;
  logic [15:0] max_val;
  logic        sat;
  logic [15:0] count;
  logic        ovf;
  logic        unf;
  logic        at_max;
  logic        at_zero;
  logic [7:0]  evt_cnt;

  int unsigned n_checks = 0;
  int unsigned n_fail   = 0;

  longint m_cnt = 0;
  longint m_evt = 0;
  bit     m_ovf = 0;
  bit     m_unf = 0;

  prog_updown_counter #(.WIDTH(16), .STEP_W(4), .EVT_W(8)) dut (
    .clk(clk), .reset(reset), .en(en), .up_down(up_down), .load(load),
    .load_val(load_val), .step(step), .max_val(max_val), .sat(sat),
    .count(count), .ovf(ovf), .unf(unf), .at_max(at_max), .at_zero(at_zero),
    .evt_cnt(evt_cnt)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input longint obs, input longint exp);
    n_checks++;
    if (obs != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, obs, exp, $time);
    end
  endtask

  // Next state from the stated rules, using unbounded integer arithmetic.
  task automatic model_step();
    longint mx, s;
    mx = max_val;
    if (load) begin
      m_cnt = (load_val < mx) ? load_val : mx;
      m_evt = 0; m_ovf = 0; m_unf = 0;
    end else if (en) begin
      s = (step < mx) ? step : mx;
      m_ovf = 0; m_unf = 0;
      if (m_cnt > mx) begin
        m_cnt = 0; m_ovf = 1;
      end else if (up_down) begin
        if (m_cnt + s > mx) begin
          m_ovf = 1;
          m_cnt = sat ? mx : m_cnt + s - (mx + 1);
        end else m_cnt = m_cnt + s;
      end else begin
        if (s > m_cnt) begin
          m_unf = 1;
          m_cnt = sat ? 0 : m_cnt + (mx + 1) - s;
        end else m_cnt = m_cnt - s;
      end
      if ((m_ovf || m_unf) && m_evt < 255) m_evt++;
    end else begin
      m_ovf = 0; m_unf = 0;
    end
  endtask

  task automatic check_all();
    check_eq("count", count, m_cnt);
    check_eq("ovf", ovf, m_ovf);
    check_eq("unf", unf, m_unf);
    check_eq("evt_cnt", evt_cnt, m_evt);
    check_eq("at_max", at_max, (m_cnt == max_val));
    check_eq("at_zero", at_zero, (m_cnt == 0));
  endtask

  task automatic cycle();
    model_step();
    @(posedge clk);
    #1;
    check_all();
  endtask

  task automatic model_reset();
    m_cnt = 0; m_evt = 0; m_ovf = 0; m_unf = 0;
  endtask

  // Pulses reset between edges; called just after a post-edge check.
  task automatic async_reset_pulse();
    #2 reset = 1'b1;
    #1;
    model_reset();
    check_eq("rst_count", count, 0);
    check_eq("rst_evt", evt_cnt, 0);
    check_eq("rst_flags", {ovf, unf}, 0);
    check_eq("rst_at_zero", at_zero, 1);
    #1 reset = 1'b0;
  endtask

  task automatic do_load(input logic [15:0] v);
    load = 1'b1; load_val = v; cycle(); load = 1'b0;
  endtask

  initial begin
    reset = 1'b1; en = 0; up_down = 1; load = 0; load_val = '0;
    step = 4'd1; max_val = 16'd9; sat = 0;
    #12;
    check_eq("reset_count", count, 0);
    check_eq("reset_evt", evt_cnt, 0);
    check_eq("reset_at_zero", at_zero, 1);
    check_eq("reset_at_max", at_max, 0);
    @(negedge clk); reset = 1'b0;

    // Load has priority over en and clamps to max_val
    max_val = 16'd15; en = 1; load = 1; load_val = 16'd20; cycle(); load = 0;
    check_eq("load_clamp", count, 15);
    check_eq("load_at_max", at_max, 1);
    check_eq("load_evt", evt_cnt, 0);

    // Wrap up: 8 + 3 over 0..9 gives 1
    max_val = 16'd9; en = 0; do_load(16'd8);
    en = 1; up_down = 1; step = 4'd3; sat = 0; cycle();
    check_eq("wrap_up_count", count, 1);
    check_eq("wrap_up_ovf", ovf, 1);
    check_eq("wrap_up_evt", evt_cnt, 1);
    en = 0; cycle();
    check_eq("wrap_up_ovf_drop", ovf, 0);

    // Wrap down: 1 - 3 gives 8, then 5
    do_load(16'd1);
    en = 1; up_down = 0; cycle();
    check_eq("wrap_dn_count", count, 8);
    check_eq("wrap_dn_unf", unf, 1);
    cycle();
    check_eq("wrap_dn_count2", count, 5);
    check_eq("wrap_dn_unf2", unf, 0);

    // Range fault after lowering max_val, then step 0 holds
    en = 0; max_val = 16'd15; do_load(16'd12);
    max_val = 16'd10; en = 1; up_down = 0; step = 4'd1; cycle();
    check_eq("fault_count", count, 0);
    check_eq("fault_ovf", ovf, 1);
    step = 4'd0; cycle(); cycle();
    check_eq("s0_count", count, 0);
    check_eq("s0_flags", {ovf, unf}, 0);

    // Saturating top of the full range; evt_cnt pins at all-ones
    en = 0; max_val = 16'hFFFF; do_load(16'hFFFE);
    en = 1; up_down = 1; step = 4'd1; sat = 1; cycle();
    check_eq("sat_reach", count, 16'hFFFF);
    check_eq("sat_reach_ovf", ovf, 0);
    for (int i = 0; i < 260; i++) cycle();
    check_eq("sat_hold", count, 16'hFFFF);
    check_eq("sat_ovf", ovf, 1);
    check_eq("sat_evt_pin", evt_cnt, 255);

    // max_val = 0 in both modes
    max_val = 16'd0; en = 0; do_load(16'd5);
    en = 1; step = 4'd7;
    for (int i = 0; i < 4; i++) begin
      sat = i[0]; up_down = i[1]; cycle();
    end

    // Async reset mid-count, then resume from 0
    max_val = 16'd100; sat = 0; up_down = 1; step = 4'd5;
    for (int i = 0; i < 5; i++) cycle();
    async_reset_pulse();
    cycle();
    check_eq("resume_count", count, 5);

    // Randomized traffic
    for (int i = 0; i < 4000; i++) begin
      if ($urandom_range(0, 49) == 0) begin
        case ($urandom_range(0, 2))
          0: max_val = 16'($urandom_range(0, 3));
          1: max_val = 16'($urandom_range(0, 40));
          default: max_val = 16'($urandom);
        endcase
      end
      load     = ($urandom_range(0, 19) == 0);
      load_val = ($urandom_range(0, 1) == 0) ? 16'($urandom_range(0, 50)) : 16'($urandom);
      en       = ($urandom_range(0, 9) != 0);
      up_down  = 1'($urandom);
      sat      = ($urandom_range(0, 3) == 0);
      step     = 4'($urandom);
      cycle();
      if ($urandom_range(0, 299) == 0) async_reset_pulse();
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
